// File: rtl/uart_rx_perif_if.sv
// Register bus of the UART receive peripheral: address, chip select,
// write strobe and write data. Read data leaves the block as a tri-state port.
interface uart_rx_perif_if;
  logic [1:0] AB;
  logic       CS;
  logic       WE;
  logic [7:0] DI;

  modport master (output AB, CS, WE, DI);
  modport slave  (input  AB, CS, WE, DI);
endinterface

// File: rtl/uart_rx_perif.sv
// 8N1 UART receiver with a small receive FIFO and a register read port.
// Sticky status bits report frame errors and FIFO overruns.
module uart_rx_perif #(
  parameter int DELAY_FRAMES = 234,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_pin,
  uart_rx_perif_if.slave   bus,
  output logic [7:0]       DO,
  output logic             rx_avail,
  output logic             test_pin
);
  localparam int CW = $clog2(DELAY_FRAMES);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(DELAY_FRAMES/2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(DELAY_FRAMES - 1);
  localparam logic [PW:0]   DEPTH   = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          s1, s2, prev;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          overrun, frame_err;
  logic          rd_sel, rd_sel_q, lat_valid;
  logic [7:0]    lat_data, head, status, rd_data;
  logic          stop_samp, push, space, do_push, ovr_set, ferr_set, pop, clr;
  logic          empty, full;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {s1, s2, prev} <= 3'b111;
    else begin
      s1   <= rx_pin;
      s2   <= s1;
      prev <= s2;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        IDLE:
          if (prev && !s2) begin
            state <= START;
            cnt   <= '0;
          end
        START:
          if (cnt == HALF_M1) begin
            // A line back high at mid start bit was a glitch, not a frame.
            if (s2) state <= IDLE;
            else begin
              state   <= DATA;
              cnt     <= '0;
              bit_idx <= '0;
            end
          end else cnt <= cnt + CW'(1);
        DATA:
          if (cnt == FULL_M1) begin
            shreg[bit_idx] <= s2;
            cnt            <= '0;
            bit_idx        <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else cnt <= cnt + CW'(1);
        STOP:
          if (cnt == FULL_M1) state <= IDLE;
          else cnt <= cnt + CW'(1);
        default: state <= IDLE;
      endcase
    end

  assign stop_samp = (state == STOP) && (cnt == FULL_M1);
  assign push      = stop_samp &  s2;
  assign ferr_set  = stop_samp & ~s2;

  assign empty  = (count == '0);
  assign full   = (count == DEPTH);
  assign head   = empty ? 8'h00 : mem[rd_ptr];
  assign rd_sel = bus.CS & ~bus.WE & (bus.AB == 2'd0);
  // Pop at the end of an access, only if the access began on a non-empty FIFO.
  assign pop    = rd_sel_q & ~rd_sel & lat_valid & ~empty;
  assign space  = ~full | pop;
  assign do_push = push & space;
  assign ovr_set = push & ~space;
  assign clr    = bus.CS & bus.WE & (bus.AB == 2'd2);

  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= shreg;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      rd_sel_q  <= 1'b0;
      lat_valid <= 1'b0;
      lat_data  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      count     <= count + (PW+1)'(do_push) - (PW+1)'(pop);
      overrun   <= ovr_set  | (overrun   & ~clr);
      frame_err <= ferr_set | (frame_err & ~clr);
      rd_sel_q  <= rd_sel;
      // Freeze the head for the rest of the access so a late push cannot alter it.
      if (rd_sel && !rd_sel_q) begin
        lat_data  <= head;
        lat_valid <= ~empty;
      end
    end

  assign status = {3'b000, test_pin, frame_err, overrun, full, ~empty};

  always_comb begin
    rd_data = 8'h00;
    case (bus.AB)
      2'd0:    rd_data = rd_sel_q ? lat_data : head;
      2'd1:    rd_data = status;
      default: rd_data = 8'h00;
    endcase
  end

  assign DO       = (bus.CS && !bus.WE) ? rd_data : 8'hzz;
  assign rx_avail = ~empty;
  assign test_pin = (state != IDLE);
endmodule

// File: tb/tb_uart_rx_perif.sv
// Self-checking bench for uart_rx_perif: directed register/frame scenarios
// plus randomized frames checked against a queue-based model.
module tb_uart_rx_perif;
  localparam int DF    = 234;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_pin = 1'b1;
  wire  [7:0] DO;
  logic       rx_avail, test_pin;
  int         n_cmp = 0;
  int         n_bad = 0;

  uart_rx_perif_if bus();

  uart_rx_perif #(.DELAY_FRAMES(DF), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .rx_pin(rx_pin), .bus(bus),
    .DO(DO), .rx_avail(rx_avail), .test_pin(test_pin)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h required %02h", name, act, exp);
    end
  endtask

  // Drive one 8N1 frame; called and returning on a negedge.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx_pin = 1'b0;
    repeat (DF) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      repeat (DF) @(negedge clk);
    end
    rx_pin = stop;
    repeat (DF) @(negedge clk);
    rx_pin = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic bus_read(input logic [1:0] ab, output logic [7:0] d);
    bus.CS = 1'b1; bus.WE = 1'b0; bus.AB = ab;
    @(negedge clk);
    d = DO;
    bus.CS = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] ab, input logic [7:0] di);
    bus.CS = 1'b1; bus.WE = 1'b1; bus.AB = ab; bus.DI = di;
    @(negedge clk);
    bus.CS = 1'b0; bus.WE = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic [1:0] ab;
    logic       we;
    logic [7:0] di;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs[14];
  logic [7:0] d;
  int         lat;
  logic [7:0] q[$];
  logic       m_ferr, m_ovr;

  initial begin
    vecs[0]  = '{2'd1, 1'b0, 8'h00, 8'h07};
    vecs[1]  = '{2'd0, 1'b1, 8'hAA, 8'h00};
    vecs[2]  = '{2'd1, 1'b1, 8'hFF, 8'h00};
    vecs[3]  = '{2'd3, 1'b1, 8'h5A, 8'h00};
    vecs[4]  = '{2'd1, 1'b0, 8'h00, 8'h07};
    vecs[5]  = '{2'd3, 1'b0, 8'h00, 8'h00};
    vecs[6]  = '{2'd0, 1'b0, 8'h00, 8'h01};
    vecs[7]  = '{2'd0, 1'b0, 8'h00, 8'h02};
    vecs[8]  = '{2'd0, 1'b0, 8'h00, 8'h03};
    vecs[9]  = '{2'd0, 1'b0, 8'h00, 8'h04};
    vecs[10] = '{2'd1, 1'b0, 8'h00, 8'h04};
    vecs[11] = '{2'd0, 1'b0, 8'h00, 8'h00};
    vecs[12] = '{2'd2, 1'b1, 8'h3C, 8'h00};
    vecs[13] = '{2'd1, 1'b0, 8'h00, 8'h00};

    bus.CS = 1'b0; bus.WE = 1'b0; bus.AB = 2'd0; bus.DI = 8'h00;
    repeat (3) @(negedge clk);
    check("reset rx_avail", {7'd0, rx_avail}, 8'h00);
    check("reset test_pin", {7'd0, test_pin}, 8'h00);
    bus_read(2'd0, d); check("reset data read", d, 8'h00);
    bus_read(2'd1, d); check("reset status", d, 8'h00);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 0x55: latency from start edge to rx_avail
    fork
      send_frame(8'h55, 1'b1);
      begin
        lat = 0;
        while (!rx_avail && lat < 3000) begin
          @(negedge clk);
          lat++;
          if (lat == 1000) check("busy mid-frame", {7'd0, test_pin}, 8'h01);
        end
      end
    join
    check("rx_avail latency in window", {7'd0, (lat >= 2215 && lat <= 2235)}, 8'h01);
    bus_read(2'd0, d); check("read 0x55", d, 8'h55);
    bus_read(2'd1, d); check("status after 0x55", d, 8'h00);

    // start-bit glitch
    rx_pin = 1'b0;
    repeat (50) @(negedge clk);
    rx_pin = 1'b1;
    repeat (300) @(negedge clk);
    check("glitch rx_avail", {7'd0, rx_avail}, 8'h00);
    bus_read(2'd1, d); check("glitch status", d, 8'h00);

    // framing error
    send_frame(8'hA5, 1'b0);
    bus_read(2'd1, d); check("frame_err status", d, 8'h08);
    bus_write(2'd2, 8'($urandom));
    bus_read(2'd1, d); check("status after clear", d, 8'h00);

    // overrun and table-driven register accesses
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    foreach (vecs[i]) begin
      if (vecs[i].we) bus_write(vecs[i].ab, vecs[i].di);
      else begin
        bus_read(vecs[i].ab, d);
        check($sformatf("vec%0d", i), d, vecs[i].exp);
      end
    end

    // push and pop of a full FIFO in the same clock
    send_frame(8'h11, 1'b1); send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1); send_frame(8'h44, 1'b1);
    bus_read(2'd1, d); check("full status", d, 8'h03);
    fork
      send_frame(8'h55, 1'b1);
      begin
        repeat (2000) @(negedge clk);
        bus.CS = 1'b1; bus.WE = 1'b0; bus.AB = 2'd0;
        @(negedge clk);
        check("head during overlap read", DO, 8'h11);
        repeat (224) @(negedge clk);
        bus.CS = 1'b0;
      end
    join
    bus_read(2'd1, d); check("no overrun on push+pop", d, 8'h03);
    bus_read(2'd0, d); check("overlap byte 1", d, 8'h22);
    bus_read(2'd0, d); check("overlap byte 2", d, 8'h33);
    bus_read(2'd0, d); check("overlap byte 3", d, 8'h44);
    bus_read(2'd0, d); check("overlap byte 4", d, 8'h55);
    bus_read(2'd1, d); check("overlap drained", d, 8'h00);

    // reset during data bit 3 of 0x3C
    rx_pin = 1'b0;
    repeat (DF) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_pin = ((8'h3C >> i) & 8'h01) != 0;
      repeat ((i == 3) ? DF/2 : DF) @(negedge clk);
    end
    check("busy before reset", {7'd0, test_pin}, 8'h01);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid-reset test_pin", {7'd0, test_pin}, 8'h00);
    check("mid-reset rx_avail", {7'd0, rx_avail}, 8'h00);
    bus_read(2'd0, d); check("mid-reset data read", d, 8'h00);
    rst_n = 1'b1;
    rx_pin = 1'b1;
    repeat (2500) @(negedge clk);
    check("after reset rx_avail", {7'd0, rx_avail}, 8'h00);
    send_frame(8'h3C, 1'b1);
    bus_read(2'd0, d); check("read 0x3C", d, 8'h3C);
    bus_read(2'd1, d); check("status after 0x3C", d, 8'h00);

    // randomized frames against a queue model
    m_ferr = 1'b0; m_ovr = 1'b0;
    for (int it = 0; it < 8; it++) begin
      logic [7:0] b;
      logic       stp;
      b   = 8'($urandom);
      stp = ($urandom_range(0, 4) != 0);
      send_frame(b, stp);
      if (!stp) m_ferr = 1'b1;
      else if (q.size() == DEPTH) m_ovr = 1'b1;
      else q.push_back(b);
      if (it == 7 || $urandom_range(0, 2) == 0) begin
        bus_read(2'd1, d);
        check("rand status", d, {3'b000, 1'b0, m_ferr, m_ovr, q.size() == DEPTH, q.size() != 0});
        while (q.size() != 0) begin
          bus_read(2'd0, d);
          check("rand data", d, q.pop_front());
        end
        bus_read(2'd0, d); check("rand empty read", d, 8'h00);
        if ($urandom_range(0, 1) == 1) begin
          bus_write(2'd2, 8'h00);
          m_ferr = 1'b0; m_ovr = 1'b0;
        end
        bus_read(2'd1, d);
        check("rand status drained", d, {4'b0000, m_ferr, m_ovr, 2'b00});
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_perif.md
UART_RX_PERIF -- requirements
Module: uart_rx_perif

Interface
REQ-001 SHALL have parameter DELAY_FRAMES, default 234, meaning clk cycles per bit (27 MHz / 115200 baud).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning receive FIFO entries (power of two).
REQ-003 SHALL have port clk  input  1  the single clock; all logic on posedge clk.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rx_pin  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 SHALL have port AB  input  2  register select.
REQ-007 SHALL have port CS  input  1  chip select, level, held for a full bus access.
REQ-008 SHALL have port WE  input  1  write strobe, qualified by CS.
REQ-009 SHALL have port DI  input  8  write data.
REQ-010 SHALL have port DO  output  8  read data: driven when CS=1 and WE=0, else high-Z.
REQ-011 SHALL have port rx_avail  output  1  FIFO non-empty.
REQ-012 SHALL have port test_pin  output  1  receiver busy (state not IDLE).

Function
REQ-013 SHALL synchronise rx_pin through 2 flops (reset value 1); a third flop holds the previous synced value for edge detection.
REQ-014 SHALL implement states IDLE, START, DATA, STOP with one bit counter, one 3-bit bit index and an 8-bit shift register.
REQ-015 IDLE: on synced falling edge (prev 1, now 0) SHALL go to START and clear the counter; otherwise stay.
REQ-016 START: at counter = DELAY_FRAMES/2-1 SHALL sample; line 0 -> DATA, counter 0, bit index 0; line 1 -> IDLE (glitch, nothing recorded).
REQ-017 DATA: at counter = DELAY_FRAMES-1 SHALL shift the sample into bit[index] and clear the counter; after index 7 -> STOP.
REQ-018 STOP: at counter = DELAY_FRAMES-1 SHALL sample; 1 -> push byte; 0 -> set frame_err sticky, discard byte; both -> IDLE.
REQ-019 Push SHALL complete in the same clock as the stop sample; rx_avail SHALL be 1 on the next clock.
REQ-020 Push when FIFO full (after the same-cycle pop is applied) SHALL drop the new byte and set overrun sticky; stored bytes are unchanged.
REQ-021 The read-data select is rd_sel = CS & ~WE & (AB=0); a pop SHALL occur on the clock where rd_sel falls 1->0, exactly once per access; if empty, no pop.
REQ-022 Simultaneous push and pop SHALL both take effect; count unchanged; pop is applied first.
REQ-023 AB=0 read SHALL return the FIFO head, or 0x00 if empty; the value is stable for the whole access.
REQ-024 AB=1 read SHALL return {3'b0, busy, frame_err, overrun, full, avail}.
REQ-025 Any write with AB=2 (CS=1, WE=1, sampled each clock) SHALL clear overrun and frame_err; a same-cycle set SHALL win over the clear.
REQ-026 AB=3 SHALL read 0x00; writes with AB=0,1,3 SHALL be ignored.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH.
REQ-028 A new falling edge during STOP SHALL be ignored; detection resumes only in IDLE.

Reset
REQ-029 rst_n=0 SHALL asynchronously force IDLE, counter/index/shift register 0, FIFO empty, stickies 0, and synchronizer flops 1.
REQ-030 While in reset: rx_avail=0, test_pin=0, DO=Z (CS=0) or 0x00 (read AB=0).
REQ-031 Reset asserted mid-frame SHALL abandon the frame; no partial byte is pushed.

Verification
REQ-032 Send 0x55 at DELAY_FRAMES=234 -> rx_avail rises about 2223 clocks after the start edge; AB=0 read = 0x55; status afterwards = 0x00.
REQ-033 Pulse rx_pin low for 50 clocks -> return to IDLE, rx_avail stays 0, status = 0x00.
REQ-034 Send 0xA5 with stop bit 0 -> status = 0x08, FIFO empty; write AB=2 -> status = 0x00.
REQ-035 Send 0x01..0x05 without reads -> status = 0x07; four reads return 0x01..0x04, then status = 0x04.
REQ-036 Finish a stop bit in the same clock as a pop of a full FIFO -> no overrun; count stays 4.
REQ-037 Pulse rst_n low during DATA bit 3 -> all outputs at reset values; the next frame 0x3C is received correctly.
